jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - queued JK flip-flop command sequencer
//
// Queues {op, count} commands in a small FIFO. It replays each op on the
// registered j/k drive for max(count,1) cycles. Commands run back to back with
// no idle cycle between them. q_model tracks the state of the downstream JK
// flip-flop.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  upstream command present
//   cmd_op     {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_count  cycles to apply cmd_op (0 behaves as 1)
//   cmd_ready  FIFO can accept a command this cycle
//   flush      synchronous abort of queued and running commands
//   j, k       registered drive to the downstream flip-flop
//   busy       command executing or FIFO non-empty
//   q_model    registered model of the downstream flip-flop state
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             flush,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             q_model
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + CNT_W;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [1:0]       jk, jk_nxt;
  logic             pop;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push;
  logic [EW-1:0]    head;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_count;

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !full && !flush;
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_op    = head[EW-1 -: 2];
  assign head_count = head[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_count};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      jk        <= 2'b00;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      jk        <= jk_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    jk_nxt        = jk;
    pop           = 1'b0;
    if (flush) begin
      state_nxt     = S_IDLE;
      remaining_nxt = '0;
      jk_nxt        = 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          jk_nxt = 2'b00;
          if (!empty) begin
            pop           = 1'b1;
            state_nxt     = S_RUN;
            jk_nxt        = head_op;
            remaining_nxt = (head_count == '0) ? CNT_W'(1) : head_count;
          end
        end
        S_RUN: begin
          // On the last cycle of a command, chain straight into the next queued one.
          if (remaining <= CNT_W'(1)) begin
            if (!empty) begin
              pop           = 1'b1;
              jk_nxt        = head_op;
              remaining_nxt = (head_count == '0) ? CNT_W'(1) : head_count;
            end else begin
              state_nxt     = S_IDLE;
              jk_nxt        = 2'b00;
              remaining_nxt = '0;
            end
          end else begin
            remaining_nxt = remaining - CNT_W'(1);
          end
        end
        default: begin
          state_nxt     = S_IDLE;
          jk_nxt        = 2'b00;
          remaining_nxt = '0;
        end
      endcase
    end
  end

  // q_model follows the j/k value already registered, so a flush does not alter its next update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_model <= 1'b0;
    end else begin
      case (jk)
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

  assign j    = jk[1];
  assign k    = jk[0];
  assign busy = (state == S_RUN) || !empty;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - directed and random checks for jk_cmd_sequencer
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_ready;
  logic             flush;
  logic             j, k, busy, q_model;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  logic [1:0] exp_op [0:4095];
  logic       q_exp;
  int         t_free, e, c, start;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_ready(cmd_ready), .flush(flush),
    .j(j), .k(k), .busy(busy), .q_model(q_model)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset_n   = 1'b0;
    step();
    reset_n   = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; flush = 1'b0; cmd_op = 2'b00; cmd_count = '0;
    for (int i = 0; i < 4096; i++) exp_op[i] = 2'b00;
    step(); step();
    chk("rst_jk", {j, k}, 2'b00);
    chk("rst_q", q_model, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    flush = 1'b1; #1;
    chk("rst_ready_flush", cmd_ready, 1'b0);
    flush = 1'b0;
    reset_n = 1'b1;
    step();

    // set for 3 cycles, starting one edge after the push
    push_cmd(2'b10, 4'd3);
    step();
    cmd_valid = 1'b0;
    chk("t1_not_yet", {j, k}, 2'b00);
    chk("t1_busy_queued", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_set", {j, k}, 2'b10);
    end
    step();
    chk("t1_end_jk", {j, k}, 2'b00);
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_end_q", q_model, 1'b1);

    // back-to-back toggles, count 0 behaves as 1
    do_reset();
    push_cmd(2'b11, 4'd0);
    step();
    push_cmd(2'b11, 4'd2);
    step();
    cmd_valid = 1'b0;
    chk("t2_c1_jk", {j, k}, 2'b11);
    chk("t2_c1_q", q_model, 1'b0);
    step();
    chk("t2_c2_jk", {j, k}, 2'b11);
    chk("t2_c2_q", q_model, 1'b1);
    step();
    chk("t2_c3_jk", {j, k}, 2'b11);
    chk("t2_c3_q", q_model, 1'b0);
    step();
    chk("t2_end_jk", {j, k}, 2'b00);
    chk("t2_end_q", q_model, 1'b1);

    // five 15-cycle holds against a 4-deep FIFO
    push_cmd(2'b00, 4'd15);
    step(); chk("t3_ready_e0", cmd_ready, 1'b1);
    step(); chk("t3_ready_e1", cmd_ready, 1'b1);
    step(); chk("t3_ready_e2", cmd_ready, 1'b1);
    step(); chk("t3_ready_e3", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk("t3_full_ready", cmd_ready, 1'b0);
    chk("t3_full_busy", busy, 1'b1);
    repeat (11) step();
    chk("t3_still_full", cmd_ready, 1'b0);
    step();
    chk("t3_after_pop", cmd_ready, 1'b1);
    repeat (59) step();
    chk("t3_last_busy", busy, 1'b1);
    chk("t3_hold_jk", {j, k}, 2'b00);
    step();
    chk("t3_done_busy", busy, 1'b0);

    // flush on the third cycle of a set
    do_reset();
    push_cmd(2'b10, 4'd8);
    step();
    push_cmd(2'b01, 4'd4);
    step();
    cmd_valid = 1'b0;
    chk("t4_set1", {j, k}, 2'b10);
    step(); chk("t4_set2", {j, k}, 2'b10);
    step(); chk("t4_set3", {j, k}, 2'b10);
    flush = 1'b1;
    push_cmd(2'b11, 4'd5);
    #1;
    chk("t4_ready_flush", cmd_ready, 1'b0);
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t4_flush_jk", {j, k}, 2'b00);
    chk("t4_flush_busy", busy, 1'b0);
    chk("t4_flush_q", q_model, 1'b1);
    step();
    chk("t4_after_jk", {j, k}, 2'b00);
    chk("t4_after_busy", busy, 1'b0);
    chk("t4_after_q", q_model, 1'b1);

    // asynchronous reset mid-run
    do_reset();
    push_cmd(2'b11, 4'd10);
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("t5_run_jk", {j, k}, 2'b11);
    chk("t5_run_q", q_model, 1'b1);
    chk("t5_run_busy", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_jk", {j, k}, 2'b00);
    chk("t5_async_q", q_model, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("t5_idle_jk", {j, k}, 2'b00);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_ready", cmd_ready, 1'b1);

    // random stream against a timeline of accepted commands
    q_exp  = 1'b0;
    t_free = 0;
    for (int it = 0; it < 340; it++) begin
      step();
      e = edge_n;
      case (exp_op[e-1])
        2'b01:   q_exp = 1'b0;
        2'b10:   q_exp = 1'b1;
        2'b11:   q_exp = ~q_exp;
        default: q_exp = q_exp;
      endcase
      chk("rnd_jk", {j, k}, exp_op[e]);
      chk("rnd_q", q_model, q_exp);
      if (it < 300) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_count = CNT_W'($urandom_range(0, 5));
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (cmd_valid && cmd_ready) begin
        c     = (cmd_count == '0) ? 1 : int'(cmd_count);
        start = (e + 2 > t_free) ? e + 2 : t_free;
        for (int x = 0; x < c; x++) exp_op[start + x] = cmd_op;
        t_free = start + c;
      end
    end
    chk("rnd_drained_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
